seq_divider8: RTL

Multi-cycle unsigned restoring divider. It computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, retiring one quotient bit per clock. The trial subtraction each cycle uses a carry-skip subtractor built from 4-bit ripple blocks. The block is the datapath core behind a tt_um pin wrapper and is the inverse arithmetic counterpart of the team's carry-skip adder.

---
 rtl/div_pkg.sv | 22 ++
 rtl/seq_divider8_csk_sub.sv | 61 ++++++
 rtl/seq_divider8.sv | 137 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential restoring divider
// Contents:
//   state_e   - controller states (IDLE, RUN, FINISH)
//   BLOCK     - ripple block width of the carry-skip subtractor
//   DEF_WIDTH - default operand width
//   cnt_width - iteration counter width for a given operand width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    localparam int BLOCK     = 4;
    localparam int DEF_WIDTH = 8;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_divider8_csk_sub.sv
// csk_sub: N-bit carry-skip subtractor computing a + ~b + 1
// Ports:
//   a    in  N  minuend
//   b    in  N  subtrahend
//   s    out N  difference a - b (mod 2^N)
//   cout out 1  carry out; 1 means no borrow (a >= b)
module csk_sub
    import div_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         cout
);

    localparam int NB = (N + BLOCK - 1) / BLOCK;
    localparam int NP = NB * BLOCK;

    // Pad bits use a=0, ~b=1: propagate set, generate clear, so they pass the
    // carry through unchanged and never break a block's skip condition. This
    // turns the short final block into a full-width one without changing cout.
    logic [NP-1:0] ap;
    logic [NP-1:0] bp;
    logic [NP-1:0] p;
    logic [NP-1:0] g;
    logic [NP-1:0] s_p;
    logic          c;
    logic          blk_c;
    logic          all_p;
    logic          unused_pad;

    assign ap = {{(NP - N){1'b0}}, a};
    assign bp = {{(NP - N){1'b1}}, ~b};
    assign p  = ap ^ bp;
    assign g  = ap & bp;

    always_comb begin
        c     = 1'b1;
        blk_c = 1'b1;
        all_p = 1'b1;
        s_p   = '0;
        for (int k = 0; k < NB; k++) begin
            blk_c = c;
            all_p = &p[k*BLOCK +: BLOCK];
            for (int i = 0; i < BLOCK; i++) begin
                s_p[k*BLOCK + i] = p[k*BLOCK + i] ^ blk_c;
                blk_c = g[k*BLOCK + i] | (p[k*BLOCK + i] & blk_c);
            end
            // When every bit propagates, the block carry-out equals its
            // carry-in, so the incoming carry bypasses the ripple chain.
            c = all_p ? c : blk_c;
        end
    end

    assign s          = s_p[N-1:0];
    assign cout       = c;
    assign unused_pad = ^s_p[NP-1:N];

endmodule

// File: rtl/seq_divider8.sv
// seq_divider8: multi-cycle unsigned restoring divider, one quotient bit per clock
// Ports:
//   clk         in  1      clock, rising edge
//   rst_n       in  1      asynchronous active-low reset
//   start       in  1      request, honoured only when busy=0
//   dividend    in  WIDTH  numerator, captured on accepted start
//   divisor     in  WIDTH  denominator, captured on accepted start
//   busy        out 1      operation in progress
//   done        out 1      one-cycle pulse when results become valid
//   quotient    out WIDTH  result, held until next accepted start
//   remainder   out WIDTH  result, held until next accepted start
//   div_by_zero out 1      divisor was zero; valid with done
module seq_divider8
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic             d_zero;
    logic             unused_msb;

    // Shift the next dividend bit into the partial remainder and try to
    // subtract the divisor from it.
    assign trial  = {r_q, q_q[WIDTH-1]};
    assign d_zero = (d_q == '0);

    csk_sub #(
        .N(WIDTH + 1)
    ) u_sub (
        .a   (trial),
        .b   ({1'b0, d_q}),
        .s   (diff),
        .cout(no_borrow)
    );

    // A successful subtraction always leaves a result below the divisor, so
    // the top bits of the trial and difference never need to be kept.
    assign unused_msb = diff[WIDTH] ^ trial[WIDTH];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        r_d         = r_q;
        d_d         = d_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d     = divisor;
                    q_d     = dividend;
                    r_d     = '0;
                    dz_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = (divisor == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                r_d     = no_borrow ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                q_d     = {q_q[WIDTH-2:0], no_borrow};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST) ? FINISH : RUN;
            end
            FINISH: begin
                // With a zero divisor no iterations ran, so Q still holds
                // the dividend and becomes the remainder.
                quotient_d  = d_zero ? '1 : q_q;
                remainder_d = d_zero ? q_q : r_q;
                dz_d        = d_zero;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            r_q         <= r_d;
            d_q         <= d_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
            done_q      <= done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dz_q;

endmodule
